md_issue_ctrl: RTL and testbench
================================

// Module: md_issue_ctrl
// PURPOSE
//  Initiator side of the MULT_DIV start/busy handshake. Sits in E stage beside the multiply/divide unit.
//  - Decodes E-stage mult/div/mthi/mtlo; drives start, instruction and operands to the unit.
//  - Keeps a cycle-exact model of unit occupancy.
//  - Stalls D-stage HI/LO-class instructions while an operation is outstanding.
//  - Freezes with the unit while an interrupt request (req) is pending.
// PARAMETERS
//  MUL_LAT  5   busy cycles after start for mult/multu; must equal the unit latency
//  DIV_LAT  10  busy cycles after start for div/divu; must equal the unit latency
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-low reset
//  req         in   1   interrupt/exception request; freezes the handshake
//  D_Ins       in   32  D-stage instruction
//  E_Ins       in   32  E-stage instruction
//  E_RS        in   32  forwarded rs value in E
//  E_RT        in   32  forwarded rt value in E
//  md_busy     in   1   busy output of the multiply/divide unit
//  md_start    out  1   start pulse to the unit (combinational)
//  md_ins      out  32  instruction to the unit (= E_Ins)
//  md_A        out  32  operand A to the unit (= E_RS)
//  md_B        out  32  operand B to the unit (= E_RT)
//  md_pending  out  1   model busy: state != IDLE (registered)
//  stall       out  1   D-stage stall request (combinational)
// BEHAVIOUR
//  Decode: op==0 and func is one of
//   mult 011000, multu 011001, div 011010, divu 011011 -> "start-class"
//   mfhi 010000, mthi 010001, mflo 010010, mtlo 010011 -> "HI/LO-class" (also includes start-class)
//  md_start = E_Ins is start-class & ~req. No start for mthi/mtlo.
//  FSM (registered state + 4-bit cnt): IDLE, MUL, DIV.
//  Reset (reset==0, async): state=IDLE, cnt=0, md_pending=0. Combinational outputs follow inputs.
//  Update priority, high to low:
//   1. req==1: state and cnt hold.
//   2. md_start: state=MUL (cnt=MUL_LAT) or DIV (cnt=DIV_LAT).
//      Applies from any state: a restart overrides an in-flight op, matching the unit.
//   3. state!=IDLE: cnt=cnt-1; if cnt==1, state=IDLE and cnt=0.
//  Timing: md_pending rises the cycle after start.
//   - high exactly MUL_LAT (5) or DIV_LAT (10) cycles when req stays low;
//   - each req-high cycle extends it by 1.
//  Stall: stall = D_Ins HI/LO-class & (md_pending | md_start).
//   - The same-cycle md_start term covers back-to-back md instructions (D follows E).
//   - Pipeline holds D and bubbles E while stall is high; stall never depends on md_busy.
//  mthi/mtlo in E while idle: no start, no state change; the unit writes HI/LO itself.
//  Reset mid-operation: model returns to IDLE at once; the unit resets on the same reset.
// CONFIGURATION
//  MD_CHECK_EN defined:
//   - extra output md_mismatch (1 bit), reset 0;
//   - sticky-set on any clk edge with req==0 and md_pending != md_busy;
//   - cleared only by reset;
//   - simulation $display on first set.
//  MD_CHECK_EN undefined: no md_mismatch port, md_busy unused (port kept for interface stability).
// TESTING
//  1. E=mult (0x00850018), RS=3, RT=-2, req=0
//     -> md_start=1 one cycle; md_pending high 5 cycles; then unit {HI,LO}=0xFFFFFFFF_FFFFFFFA.
//  2. E=divu, D=mflo in the same cycle
//     -> stall=1 for 11 cycles (start cycle + 10 busy); mflo reads LO = quotient.
//  3. E=div issued; req=1 for 3 cycles at busy cycle 4
//     -> cnt frozen; md_pending high 13 cycles total; md_start=0 for any start-class E during req.
//  4. E=mthi, D=add, idle
//     -> md_start=0, stall=0, md_pending=0.
//  5. reset=0 asynchronously at busy cycle 2 of mult
//     -> md_pending=0 immediately; a mult after release completes in 5 cycles.
//  6. MD_CHECK_EN: force md_busy=0 during modelled busy
//     -> md_mismatch=1 next edge and stays 1.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl
//   Initiator side of the multiply/divide start/busy handshake, sitting in the
//   E stage next to the multiply/divide unit. It decodes mult/multu/div/divu
//   in E, issues the start pulse with the instruction and operands, and keeps
//   a cycle-exact model of unit occupancy. D-stage HI/LO-class instructions
//   are stalled while an operation is outstanding or being started. While
//   req is high the model freezes together with the unit.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req        in   interrupt/exception request, freezes the handshake
//   D_Ins      in   D-stage instruction
//   E_Ins      in   E-stage instruction
//   E_RS/E_RT  in   forwarded operands in E
//   md_busy    in   busy flag from the unit (only observed with MD_CHECK_EN)
//   md_start   out  start pulse (combinational)
//   md_ins     out  instruction to the unit (E_Ins)
//   md_A/md_B  out  operands to the unit (E_RS / E_RT)
//   md_pending out  registered model-busy flag
//   stall      out  D-stage stall request (combinational)
//   md_mismatch out sticky model/unit disagreement flag (MD_CHECK_EN only)
//
// Optional feature: define MD_CHECK_EN to add the md_mismatch checker.

module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] D_Ins,
    input  logic [31:0] E_Ins,
    input  logic [31:0] E_RS,
    input  logic [31:0] E_RT,
    input  logic        md_busy,
    output logic        md_start,
    output logic [31:0] md_ins,
    output logic [31:0] md_A,
    output logic [31:0] md_B,
    output logic        md_pending,
`ifdef MD_CHECK_EN
    output logic        stall,
    output logic        md_mismatch
`else
    output logic        stall
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pending_q, pending_d;
    logic       e_start_class;
    logic       e_is_div;
    logic       d_hilo_class;

    // mult/multu/div/divu share func[5:2] = 0110; func[1] separates div.
    assign e_start_class = (E_Ins[31:26] == 6'd0) && (E_Ins[5:2] == 4'b0110);
    assign e_is_div      = E_Ins[1];
    // HI/LO class: func 0100xx (mfhi/mthi/mflo/mtlo) or 0110xx (start class).
    assign d_hilo_class  = (D_Ins[31:26] == 6'd0) && (D_Ins[5:4] == 2'b01) && (D_Ins[2] == 1'b0);

    assign md_start   = e_start_class & ~req;
    assign md_ins     = E_Ins;
    assign md_A       = E_RS;
    assign md_B       = E_RT;
    assign md_pending = pending_q;
    // The md_start term catches a HI/LO instruction in D directly behind a
    // starting op in E, before the model has registered the new occupancy.
    assign stall      = d_hilo_class & (pending_q | md_start);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!req) begin
            if (md_start) begin
                // A restart overrides an in-flight op, as the unit does.
                if (e_is_div) begin
                    state_d = ST_DIV;
                    cnt_d   = 4'(DIV_LAT);
                end else begin
                    state_d = ST_MUL;
                    cnt_d   = 4'(MUL_LAT);
                end
            end else if (state_q != ST_IDLE) begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        end
        pending_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

`ifdef MD_CHECK_EN
    logic mismatch_q, mismatch_d;

    assign mismatch_d  = mismatch_q | (~req & (pending_q ^ md_busy));
    assign md_mismatch = mismatch_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset && mismatch_d && !mismatch_q) begin
            $display("md_issue_ctrl: model busy %0b disagrees with unit busy %0b at %0t",
                     pending_q, md_busy, $time);
        end
    end
`endif
`endif

    // Bits that carry no meaning for this block (md_busy only feeds the
    // optional checker; the rest of D_Ins is irrelevant to the class decode).
    logic unused_ok;
    assign unused_ok = &{1'b0, md_busy, D_Ins[25:6], D_Ins[3]};

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios with literal expectations plus
// a cycles-remaining occupancy model compared on every falling edge.
module tb_md_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] MULT = 32'h0085_0018;
    localparam logic [31:0] DIV  = 32'h0085_001A;
    localparam logic [31:0] DIVU = 32'h0085_001B;
    localparam logic [31:0] MFLO = 32'h0000_4012;
    localparam logic [31:0] MTHI = 32'h0080_0011;
    localparam logic [31:0] ADD  = 32'h0085_3020;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] D_Ins, E_Ins, E_RS, E_RT;
    logic        md_busy;
    logic        md_start, md_pending, stall;
    logic [31:0] md_ins, md_A, md_B;

    int checks = 0;
    int errors = 0;
    int rem = 0;
    int pc, sc;

    md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .D_Ins      (D_Ins),
        .E_Ins      (E_Ins),
        .E_RS       (E_RS),
        .E_RT       (E_RT),
        .md_busy    (md_busy),
        .md_start   (md_start),
        .md_ins     (md_ins),
        .md_A       (md_A),
        .md_B       (md_B),
        .md_pending (md_pending),
        .stall      (stall)
    );

    always #5 clk = ~clk;

    function automatic bit is_start(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) &&
               (ins[5:0] == 6'h18 || ins[5:0] == 6'h19 || ins[5:0] == 6'h1A || ins[5:0] == 6'h1B);
    endfunction

    function automatic bit is_hilo(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) &&
               (is_start(ins) || ins[5:0] == 6'h10 || ins[5:0] == 6'h11 ||
                ins[5:0] == 6'h12 || ins[5:0] == 6'h13);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Occupancy model: number of cycles the unit still has to run.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem = 0;
        end else if (!req) begin
            if (is_start(E_Ins))
                rem = (E_Ins[5:0] == 6'h1A || E_Ins[5:0] == 6'h1B) ? DIV_LAT : MUL_LAT;
            else if (rem > 0)
                rem = rem - 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            bit exp_start;
            exp_start = is_start(E_Ins) && !req;
            check("cmp_start",   md_start,   exp_start);
            check("cmp_stall",   stall,      is_hilo(D_Ins) && (rem > 0 || exp_start));
            check("cmp_pending", md_pending, rem > 0);
            check("cmp_ins",     md_ins,     E_Ins);
            check("cmp_A",       md_A,       E_RS);
            check("cmp_B",       md_B,       E_RT);
        end
    end

    initial begin
        reset = 1'b0; req = 1'b0; md_busy = 1'b0;
        D_Ins = NOP; E_Ins = NOP; E_RS = 32'd0; E_RT = 32'd0;
        #2;
        check("rst_pending", md_pending, 0);
        check("rst_start",   md_start,   0);
        check("rst_stall",   stall,      0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // mult 3 * -2
        E_Ins = MULT; E_RS = 32'd3; E_RT = 32'hFFFF_FFFE;
        @(negedge clk);
        check("t1_start", md_start, 1);
        check("t1_A",     md_A,     32'd3);
        check("t1_B",     md_B,     32'hFFFF_FFFE);
        check("t1_ins",   md_ins,   MULT);
        @(posedge clk); #1 E_Ins = NOP;
        pc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); pc += int'(md_pending);
            @(posedge clk); #1;
        end
        check("t1_pend_cycles", pc, 5);

        // divu in E with mflo behind it in D
        D_Ins = MFLO; E_Ins = DIVU; sc = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); sc += int'(stall);
            @(posedge clk); #1 E_Ins = NOP;
        end
        check("t2_stall_cycles", sc, 11);
        D_Ins = NOP;

        // div frozen by req at busy cycles 4..6, mult offered during req
        E_Ins = DIV; pc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); pc += int'(md_pending);
            if (req) check("t3_start_in_req", md_start, 0);
            @(posedge clk); #1;
            req   = (i + 1 >= 4) && (i + 1 <= 6);
            E_Ins = req ? MULT : NOP;
        end
        check("t3_pend_cycles", pc, 13);

        // mthi in E while idle
        E_Ins = MTHI; D_Ins = ADD;
        @(negedge clk);
        check("t4_start",   md_start,   0);
        check("t4_stall",   stall,      0);
        check("t4_pending", md_pending, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_pending_next", md_pending, 0);
        @(posedge clk); #1 E_Ins = NOP; D_Ins = NOP;

        // asynchronous reset in the middle of a mult
        E_Ins = MULT;
        @(posedge clk); #1 E_Ins = NOP; D_Ins = MFLO;
        @(posedge clk); #2;
        check("t5_busy_before", md_pending, 1);
        reset = 1'b0;
        #1;
        check("t5_pending_rst", md_pending, 0);
        check("t5_stall_rst",   stall,      0);
        @(posedge clk); #1 reset = 1'b1;
        E_Ins = MULT;
        @(posedge clk); #1 E_Ins = NOP;
        pc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); pc += int'(md_pending);
            @(posedge clk); #1;
        end
        check("t5_pend_cycles", pc, 5);
        D_Ins = NOP;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
